// File: rtl/psk_modulator.sv
// psk_modulator
//   BPSK/QPSK carrier modulator. Symbols arrive over a valid/ready handshake.
//   Each symbol becomes one carrier period of phase-shifted sine samples in
//   offset-binary. The packet mode is latched when a start is accepted.
//
// Optional feature macro: PSK_DIFF_EN
//   When defined, each symbol's offset is added (mod WAVELENGTH) to the
//   previous symbol's phase. The running phase is cleared on an accepted start.
//   When undefined, the phase is absolute per symbol.
//
// Parameters
//   DATA_WIDTH      sample width
//   WAVELENGTH      samples per carrier period / symbol (multiple of 4, >= 8)
//   PACKET_SYMBOLS  symbols per packet (>= 1)
//
// Ports
//   clk, rst          clock, async active-high reset
//   start, mode       packet start pulse, 0 = BPSK / 1 = QPSK
//   sym_data          symbol (BPSK uses bit 0)
//   sym_valid         symbol valid
//   sym_ready         symbol ready
//   sample_out        DAC sample; midscale whenever sample_valid is low
//   sample_valid      sample_out carries a carrier sample
//   busy              FSM active or pipeline not yet drained
//   done              pulse on the last sample of a packet
//   underflow         sticky; a symbol was missing at a symbol boundary
module psk_modulator #(
  parameter int DATA_WIDTH     = 8,
  parameter int WAVELENGTH     = 16,
  parameter int PACKET_SYMBOLS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [1:0]            sym_data,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow
);

  localparam int AW = $clog2(WAVELENGTH);
  localparam int CW = $clog2(PACKET_SYMBOLS + 1);

  localparam logic [DATA_WIDTH-1:0] MIDSCALE  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam longint                AMP       = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
  localparam longint                PI_HALF_Q = 64'sd1686629713;  // pi/2 * 2^30

  localparam logic [AW:0]   W_EXT     = WAVELENGTH[AW:0];
  localparam logic [AW-1:0] W_LAST    = AW'(WAVELENGTH - 1);
  localparam logic [AW-1:0] W_QTR     = AW'(WAVELENGTH / 4);
  localparam logic [AW-1:0] W_HALF    = AW'(WAVELENGTH / 2);
  localparam logic [AW-1:0] W_3QTR    = AW'((3 * WAVELENGTH) / 4);
  localparam logic [CW-1:0] COUNT_MAX = CW'(PACKET_SYMBOLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } state_t;

  // (a + b) mod WAVELENGTH with both operands already in range, so a single
  // conditional subtract is enough and no out-of-range value is ever produced.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    logic [AW:0] total;
    total = {1'b0, a} + {1'b0, b};
    if (total >= W_EXT) total = total - W_EXT;
    return total[AW-1:0];
  endfunction

  // Sine table entry, evaluated at elaboration. The angle is folded into the
  // first quadrant and a Taylor series is run in Q30 fixed point, which keeps
  // every intermediate product inside 64 bits.
  function automatic logic [DATA_WIDTH-1:0] sine_entry(input int p);
    longint x, x2, term, acc, mag;
    int     quarter, q, r;
    quarter = WAVELENGTH / 4;
    q       = p / quarter;
    r       = p % quarter;
    if (q[0]) r = quarter - r;
    x    = (PI_HALF_Q * longint'(r)) / longint'(quarter);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k < 12; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    mag = (AMP * acc + (64'sd1 <<< 29)) >>> 30;
    if (q >= 2) return MIDSCALE - DATA_WIDTH'(mag);
    return MIDSCALE + DATA_WIDTH'(mag);
  endfunction

  logic [DATA_WIDTH-1:0] rom [WAVELENGTH];

  for (genvar p = 0; p < WAVELENGTH; p++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] ENTRY = sine_entry(p);
    assign rom[p] = ENTRY;
  end

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [AW-1:0]         index_q, index_d;
  logic [AW-1:0]         offset_q, offset_d;
  logic [CW-1:0]         sym_count_q, sym_count_d;
  logic                  underflow_q, underflow_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  s0_valid_q, s0_valid_d;
  logic                  s0_done_q, s0_done_d;
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  valid_q;
  logic                  done_q;

  logic                  ready_c;
  logic                  busy_c;
  logic [AW-1:0]         sym_offset;
  logic [AW-1:0]         new_offset;

  assign busy_c = (state_q != IDLE) | s0_valid_q | valid_q;

  always_comb begin
    sym_offset = '0;
    if (!mode_q) begin
      sym_offset = sym_data[0] ? W_HALF : '0;
    end else begin
      case (sym_data)
        2'b00:   sym_offset = '0;
        2'b01:   sym_offset = W_QTR;
        2'b11:   sym_offset = W_HALF;
        default: sym_offset = W_3QTR;
      endcase
    end
  end

`ifdef PSK_DIFF_EN
  // offset_q doubles as the running phase: it is cleared on start.
  assign new_offset = mod_add(offset_q, sym_offset);
`else
  assign new_offset = sym_offset;
`endif

  assign addr_d     = mod_add(index_q, offset_q);
  assign s0_valid_d = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    index_d     = index_q;
    offset_d    = offset_q;
    sym_count_d = sym_count_q;
    underflow_d = underflow_q;
    ready_c     = 1'b0;
    s0_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A start arriving while the pipeline still drains is not accepted.
        if (start && !busy_c) begin
          mode_d      = mode;
          sym_count_d = '0;
          underflow_d = 1'b0;
          offset_d    = '0;
          index_d     = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        ready_c = 1'b1;
        // Past the first symbol, being here means a boundary was missed.
        if (sym_count_q != '0) underflow_d = 1'b1;
        if (sym_valid) begin
          offset_d    = new_offset;
          index_d     = '0;
          sym_count_d = sym_count_q + CW'(1);
          state_d     = RUN;
        end
      end
      RUN: begin
        if (index_q == W_LAST) begin
          index_d = '0;
          if (sym_count_q < COUNT_MAX) begin
            ready_c = 1'b1;
            if (sym_valid) begin
              offset_d    = new_offset;
              sym_count_d = sym_count_q + CW'(1);
            end else begin
              state_d = FETCH;
            end
          end else begin
            s0_done_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          index_d = index_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      index_q     <= '0;
      offset_q    <= '0;
      sym_count_q <= '0;
      underflow_q <= 1'b0;
      addr_q      <= '0;
      s0_valid_q  <= 1'b0;
      s0_done_q   <= 1'b0;
      sample_q    <= MIDSCALE;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      index_q     <= index_d;
      offset_q    <= offset_d;
      sym_count_q <= sym_count_d;
      underflow_q <= underflow_d;
      addr_q      <= addr_d;
      s0_valid_q  <= s0_valid_d;
      s0_done_q   <= s0_done_d;
      // Synchronous ROM read lands directly in the output register.
      sample_q    <= s0_valid_q ? rom[addr_q] : MIDSCALE;
      valid_q     <= s0_valid_q;
      done_q      <= s0_done_q;
    end
  end

  assign sym_ready    = ready_c;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_c;
  assign done         = done_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_psk_modulator.sv
module tb_psk_modulator;
  localparam int DW  = 8;
  localparam int W   = 16;
  localparam int P   = 4;
  localparam int MID = 1 << (DW - 1);
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [1:0]    sym_data;
  logic          sym_valid;
  logic          sym_ready;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          busy;
  logic          done;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  bit [1:0] syms [P];
  int       exp_q [$];

  psk_modulator #(
    .DATA_WIDTH    (DW),
    .WAVELENGTH    (W),
    .PACKET_SYMBOLS(P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .sym_data    (sym_data),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ideal carrier sample, rounded half away from zero, in offset binary.
  function automatic int sine_ref(int p);
    real v;
    v = real'(MID - 1) * $sin(2.0 * PI * real'(p) / real'(W));
    return (v >= 0.0 ? $rtoi(v + 0.5) : $rtoi(v - 0.5)) + MID;
  endfunction

  // BPSK: bit0 selects half a period. QPSK: Gray code -> binary quadrant count.
  function automatic int sym_phase(bit m, bit [1:0] s);
    int quadrant;
    if (!m) return s[0] ? W / 2 : 0;
    quadrant = 2 * s[1] + (s[1] ^ s[0]);
    return quadrant * W / 4;
  endfunction

  task automatic build_expected(input bit m);
    int phase;
    exp_q.delete();
    phase = 0;
    for (int k = 0; k < P; k++) begin
`ifdef PSK_DIFF_EN
      phase = (phase + sym_phase(m, syms[k])) % W;
`else
      phase = sym_phase(m, syms[k]);
`endif
      for (int i = 0; i < W; i++) exp_q.push_back(sine_ref((i + phase) % W));
    end
  endtask

  // exp_gap < 0: gap count not checked. glitch_at / rst_at < 0: disabled.
  task automatic run_packet(input bit m, input int pct, input int drop_at, input int drop_len,
                            input int exp_gap, input int glitch_at, input int rst_at);
    int  seen, src, t_xfer, first_cyc, gaps, drop_left, c;
    bit  finished, aborted, dropped, glitched, last, vnow;
    build_expected(m);
    c = 0;
    while (busy && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("idle_before_start", busy, 0);
    start = 1'b1;
    mode  = m;
    sym_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    check_val("uflow_cleared", underflow, 0);
    seen = 0; src = 0; t_xfer = -1; first_cyc = -1; gaps = 0; drop_left = 0;
    finished = 0; aborted = 0; dropped = 0; glitched = 0;
    for (c = 1; c < 3000 && !finished; c++) begin
      if (sample_valid) begin
        seen++;
        if (first_cyc < 0) begin
          first_cyc = c;
          check_val("first_latency", c - t_xfer, 3);
        end
        if (exp_q.size() == 0) begin
          check_val("extra_sample", seen, P * W);
        end else begin
          last = (exp_q.size() == 1);
          check_val("sample", sample_out, exp_q.pop_front());
          check_val("done_pos", done, last);
        end
        if (done) finished = 1;
      end else begin
        if (first_cyc >= 0) gaps++;
        check_val("done_no_valid", done, 0);
        check_val("idle_midscale", sample_out, MID);
      end
      if (rst_at >= 0 && seen == rst_at) begin
        rst = 1'b1;
        sym_valid = 1'b0;
        #1;
        check_val("rst_sample", sample_out, MID);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", sym_ready, 0);
        check_val("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        aborted = 1;
        break;
      end
      if (!finished) begin
        if (glitch_at >= 0 && seen == glitch_at && !glitched) begin
          start = 1'b1;
          mode  = ~m;
          glitched = 1;
        end else begin
          start = 1'b0;
        end
        if (drop_len > 0 && seen == drop_at && !dropped) begin
          drop_left = drop_len;
          dropped = 1;
        end
        vnow = (src < P) && (drop_left == 0) && ($urandom_range(99) < pct);
        if (drop_left > 0) drop_left--;
        sym_valid = vnow;
        sym_data  = vnow ? syms[src] : 2'($urandom);
        #1;
        if (sym_valid && sym_ready) begin
          if (t_xfer < 0) t_xfer = c;
          src++;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    sym_valid = 1'b0;
    if (!aborted) begin
      check_val("done_seen", finished, 1);
      check_val("sample_count", seen, P * W);
      check_val("symbols_used", src, P);
      check_val("busy_fall", busy, 0);
      check_val("ready_idle", sym_ready, 0);
      if (exp_gap >= 0) check_val("gap_cycles", gaps, exp_gap);
      check_val("underflow", underflow, gaps > 0);
      for (int i = 0; i < 3; i++) begin
        check_val("no_extra_done", done, 0);
        check_val("no_extra_valid", sample_valid, 0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    sym_valid = 1'b0;
    sym_data = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_sample", sample_out, MID);
    check_val("reset_valid", sample_valid, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_ready", sym_ready, 0);
    check_val("reset_done", done, 0);
    check_val("reset_uflow", underflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // BPSK, fully fed
    syms = '{2'd0, 2'd1, 2'd0, 2'd1};
    run_packet(1'b0, 100, -1, 0, 0, -1, -1);

    // QPSK Gray map
    syms = '{2'd0, 2'd1, 2'd3, 2'd2};
    run_packet(1'b1, 100, -1, 0, 0, -1, -1);

    // Underflow: valid dropped for 5 cycles starting at the first boundary
    syms = '{2'd1, 2'd3, 2'd0, 2'd2};
    run_packet(1'b1, 100, 14, 5, 5, -1, -1);

    // Reset mid-packet, then a clean packet
    syms = '{2'd1, 2'd0, 2'd1, 2'd1};
    run_packet(1'b0, 100, -1, 0, -1, -1, 20);
    syms = '{2'd2, 2'd1, 2'd0, 2'd3};
    run_packet(1'b1, 100, -1, 0, 0, -1, -1);

    // start while busy with a different mode
    syms = '{2'd3, 2'd1, 2'd2, 2'd0};
    run_packet(1'b1, 100, -1, 0, 0, 10, -1);

`ifdef PSK_DIFF_EN
    syms = '{2'd1, 2'd1, 2'd0, 2'd0};
    run_packet(1'b0, 100, -1, 0, 0, -1, -1);
`endif

    // Randomized symbols, mode and valid pattern
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < P; k++) syms[k] = 2'($urandom);
      run_packet(1'($urandom), 40 + 10 * (n % 5), -1, 0, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
